pipe_stage_reg: RTL

Parametrised pipeline stage register for the in-order core: the generalised successor of the fixed MEM/WB latch. It carries an arbitrary-width payload between two stages using a valid/ready handshake, and supports backpressure, flush and bubble zeroing. With SKID=1 it adds a skid entry, so in_ready is registered and the ready path between stages is cut. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 50 +++++
 rtl/pipe_slot.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order core's stage-boundary registers.
//   - Occupancy encodings reported by pipe_stage_reg.
//   - Default payload width.
//   - Packed payload structs, one per stage boundary.
//   - occ_of(): occupancy count from the two slot valid bits.
package pipe_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  // The skid slot is only ever valid when the main slot is, so a plain sum
  // of the two valid bits is the entry count.
  function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload entry: a DATA_W data register plus its valid bit.
//   clk, reset  : clock and asynchronous active-high reset
//   clear       : squash entry and zero its data (highest priority)
//   load        : capture load_data and mark valid
//   drop        : mark invalid, data retained
//   valid, data : current entry contents
module pipe_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (drop) begin
      // Data is kept so an unzeroed bubble still shows the last payload.
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register placed at each stage boundary.
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous squash of all held entries
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   occupancy           : entries held (0..2)
// SKID=1 adds a second entry so in_ready can be registered; SKID=0 is a
// single entry with combinational in_ready. ZERO_BUBBLE=1 masks out_data
// to zero whenever out_valid is low.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DEFAULT_DATA_W,
  parameter bit          SKID        = 1'b1,
  parameter bit          ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_load, main_drop, skid_load, skid_drop;
  logic [DATA_W-1:0] main_load_data;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  // Slot control; flush is applied inside the slots as clear, which
  // overrides any load/drop decided here.
  always_comb begin
    main_load      = 1'b0;
    main_drop      = 1'b0;
    skid_load      = 1'b0;
    skid_drop      = 1'b0;
    main_load_data = in_data;
    if (skid_valid) begin
      // Full: in_ready is low, only the drain side can move.
      if (out_xfer) begin
        main_load      = 1'b1;
        main_load_data = skid_data;
        skid_drop      = 1'b1;
      end
    end else if (main_valid) begin
      if (in_xfer && out_xfer) begin
        main_load = 1'b1;
      end else if (in_xfer) begin
        skid_load = 1'b1;
      end else if (out_xfer) begin
        main_drop = 1'b1;
      end
    end else if (in_xfer) begin
      main_load = 1'b1;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .load      (main_load),
    .drop      (main_drop),
    .load_data (main_load_data),
    .valid     (main_valid),
    .data      (main_data)
  );

  if (SKID) begin : g_skid
    logic in_ready_q;
    logic next_full;

    pipe_slot #(
      .DATA_W (DATA_W)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .load      (skid_load),
      .drop      (skid_drop),
      .load_data (in_data),
      .valid     (skid_valid),
      .data      (skid_data)
    );

    // Full next cycle if it stays full, or fills from one entry.
    assign next_full = skid_valid ? ~out_xfer : (main_valid & in_xfer & ~out_xfer);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        in_ready_q <= 1'b1;
      end else begin
        in_ready_q <= flush | ~next_full;
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign in_ready   = ~main_valid | out_ready;
  end

  assign out_valid = main_valid;
  assign occupancy = occ_of(main_valid, skid_valid);

  if (ZERO_BUBBLE) begin : g_zero_bubble
    assign out_data = main_data & {DATA_W{main_valid}};
  end else begin : g_raw_data
    assign out_data = main_data;
  end

endmodule
